// File: rtl/bus_arbiter.sv
// ============================================================================
// bus_arbiter: round-robin two-master arbiter for the single-word peripheral bus
// Revision: 1.0
// ============================================================================
`default_nettype none

module bus_arbiter #(
  parameter int unsigned WAIT    = 1,
  parameter int unsigned ADDR_HI = 31
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic [ADDR_HI-2:0]  m0_addr,
  input  logic [31:0]         m0_wd,
  input  logic                m0_we,
  output logic                m0_gnt,
  output logic                m0_ack,
  input  logic                m1_req,
  input  logic [ADDR_HI-2:0]  m1_addr,
  input  logic [31:0]         m1_wd,
  input  logic                m1_we,
  output logic                m1_gnt,
  output logic                m1_ack,
  output logic [31:0]         rdata,
  output logic [ADDR_HI-2:0]  pr_addr,
  output logic [31:0]         pr_wd,
  output logic                pr_we,
  input  logic [31:0]         pr_rd,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  state_t              state;
  state_t              state_n;
  logic                owner;
  logic                last;
  logic [3:0]          cnt;
  logic [ADDR_HI-2:0]  lat_addr;
  logic [31:0]         lat_wd;
  logic                lat_we;
  logic                any_req;
  logic                sel;

  assign any_req = m0_req | m1_req;
  // On a tie the master that did not go last wins; a lone requester always wins.
  assign sel     = (m0_req & m1_req) ? ~last : m1_req;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (any_req) state_n = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= 1'b0;
      last     <= 1'b1;
      cnt      <= 4'd0;
      lat_addr <= '0;
      lat_wd   <= 32'd0;
      lat_we   <= 1'b0;
      rdata    <= 32'd0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner    <= sel;
            cnt      <= WAIT_CNT;
            lat_addr <= sel ? m1_addr : m0_addr;
            lat_wd   <= sel ? m1_wd   : m0_wd;
            lat_we   <= sel ? m1_we   : m0_we;
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (!lat_we) begin
            rdata <= pr_rd;
          end
        end
        RESP: last <= owner;
        default: ;
      endcase
    end
  end

  // Outputs decode only from registered state, so reset clears them without a clock.
  always_comb begin
    busy    = 1'b0;
    m0_gnt  = 1'b0;
    m1_gnt  = 1'b0;
    m0_ack  = 1'b0;
    m1_ack  = 1'b0;
    pr_addr = '0;
    pr_wd   = 32'd0;
    pr_we   = 1'b0;
    if (state != IDLE) begin
      busy   = 1'b1;
      m0_gnt = ~owner;
      m1_gnt = owner;
    end
    if (state == ACCESS) begin
      pr_addr = lat_addr;
      pr_wd   = lat_wd;
      pr_we   = lat_we & (cnt == 4'd0);
    end
    if (state == RESP) begin
      m0_ack = ~owner;
      m1_ack = owner;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
// tb_bus_arbiter: directed checks of bus_arbiter at WAIT = 0, 1 and 2
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [29:0] m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_wd = '0, m1_wd = '0, pr_rd = '0;

  logic [2:0]  g0, g1, a0, a1, we_o, busy_o;
  logic [29:0] ad_o [3];
  logic [31:0] wd_o [3];
  logic [31:0] rd_o [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Instance i runs with WAIT = i; all share the same stimulus.
  generate
    for (genvar i = 0; i < 3; i++) begin : g_dut
      bus_arbiter #(.WAIT(i), .ADDR_HI(31)) u_dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wd(m0_wd), .m0_we(m0_we),
        .m0_gnt(g0[i]), .m0_ack(a0[i]),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wd(m1_wd), .m1_we(m1_we),
        .m1_gnt(g1[i]), .m1_ack(a1[i]),
        .rdata(rd_o[i]), .pr_addr(ad_o[i]), .pr_wd(wd_o[i]), .pr_we(we_o[i]),
        .pr_rd(pr_rd), .busy(busy_o[i])
      );
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
    m0_addr = '0; m1_addr = '0; m0_wd = '0; m1_wd = '0; pr_rd = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", {31'd0, busy_o[i]}, 32'd0);
      chk("rst_gnt",  {30'd0, g1[i], g0[i]}, 32'd0);
      chk("rst_ack",  {30'd0, a1[i], a0[i]}, 32'd0);
      chk("rst_rdata", rd_o[i], 32'd0);
      chk("rst_praddr", {2'd0, ad_o[i]}, 32'd0);
      chk("rst_prwe", {31'd0, we_o[i]}, 32'd0);
    end

    // WAIT=1 read by m0
    m0_req = 1'b1; m0_addr = 30'h1FC0; m0_we = 1'b0; pr_rd = 32'h1234_5678;
    tick();
    chk("rd_c1_gnt", {31'd0, g0[1]}, 32'd1);
    chk("rd_c1_addr", {2'd0, ad_o[1]}, 32'h1FC0);
    chk("rd_c1_we", {31'd0, we_o[1]}, 32'd0);
    chk("rd_c1_ack", {31'd0, a0[1]}, 32'd0);
    tick();
    chk("rd_c2_addr", {2'd0, ad_o[1]}, 32'h1FC0);
    chk("rd_c2_we", {31'd0, we_o[1]}, 32'd0);
    chk("rd_c2_ack", {31'd0, a0[1]}, 32'd0);
    tick();
    chk("rd_c3_ack", {31'd0, a0[1]}, 32'd1);
    chk("rd_c3_gnt", {31'd0, g0[1]}, 32'd1);
    chk("rd_c3_rdata", rd_o[1], 32'h1234_5678);
    chk("rd_c3_addr", {2'd0, ad_o[1]}, 32'd0);
    m0_req = 1'b0;
    tick();
    chk("rd_c4_ack", {31'd0, a0[1]}, 32'd0);
    chk("rd_c4_busy", {31'd0, busy_o[1]}, 32'd0);

    // WAIT=2 write by m1
    do_reset();
    m1_req = 1'b1; m1_addr = 30'h1FC1; m1_wd = 32'hDEAD_BEEF; m1_we = 1'b1;
    tick();
    chk("wr_c1_gnt", {31'd0, g1[2]}, 32'd1);
    chk("wr_c1_we", {31'd0, we_o[2]}, 32'd0);
    tick();
    chk("wr_c2_we", {31'd0, we_o[2]}, 32'd0);
    tick();
    chk("wr_c3_we", {31'd0, we_o[2]}, 32'd1);
    chk("wr_c3_wd", wd_o[2], 32'hDEAD_BEEF);
    chk("wr_c3_addr", {2'd0, ad_o[2]}, 32'h1FC1);
    chk("wr_c3_ack", {31'd0, a1[2]}, 32'd0);
    tick();
    chk("wr_c4_ack1", {31'd0, a1[2]}, 32'd1);
    chk("wr_c4_ack0", {31'd0, a0[2]}, 32'd0);
    chk("wr_c4_we", {31'd0, we_o[2]}, 32'd0);
    chk("wr_c4_rdata", rd_o[2], 32'd0);
    m1_req = 1'b0; m1_we = 1'b0;
    tick();
    chk("wr_c5_ack1", {31'd0, a1[2]}, 32'd0);

    // Fairness at WAIT=1: both hold req, owners alternate every 4 cycles
    do_reset();
    m0_req = 1'b1; m0_addr = 30'h0AA; m1_req = 1'b1; m1_addr = 30'h0BB;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr_gnt0", {31'd0, g0[1]}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_gnt1", {31'd0, g1[1]}, (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("rr_addr", {2'd0, ad_o[1]}, (k % 2 == 0) ? 32'h0AA : 32'h0BB);
      tick();
      tick();
      chk("rr_ack0", {31'd0, a0[1]}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_ack1", {31'd0, a1[1]}, (k % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      chk("rr_idle", {31'd0, busy_o[1]}, 32'd0);
    end

    // Payload change and req drop after grant at WAIT=1
    do_reset();
    m0_req = 1'b1; m0_addr = 30'h100; m0_we = 1'b0;
    tick();
    chk("pl_c1_addr", {2'd0, ad_o[1]}, 32'h100);
    m0_addr = 30'h200; m0_req = 1'b0;
    tick();
    chk("pl_c2_addr", {2'd0, ad_o[1]}, 32'h100);
    tick();
    chk("pl_c3_ack", {31'd0, a0[1]}, 32'd1);
    tick();
    chk("pl_c4_ack", {31'd0, a0[1]}, 32'd0);
    chk("pl_c4_busy", {31'd0, busy_o[1]}, 32'd0);

    // Reset during the final ACCESS cycle of an m1 write at WAIT=1
    do_reset();
    m1_req = 1'b1; m1_addr = 30'h0CC; m1_wd = 32'h5555_AAAA; m1_we = 1'b1;
    tick();
    tick();
    chk("ar_pre_we", {31'd0, we_o[1]}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_we_drop", {31'd0, we_o[1]}, 32'd0);
    chk("ar_busy", {31'd0, busy_o[1]}, 32'd0);
    tick();
    chk("ar_no_ack", {31'd0, a1[1]}, 32'd0);
    reset = 1'b0;
    m0_req = 1'b1; m0_addr = 30'h0DD; m0_we = 1'b0;
    tick();
    chk("ar_next_g0", {31'd0, g0[1]}, 32'd1);
    chk("ar_next_g1", {31'd0, g1[1]}, 32'd0);
    chk("ar_next_addr", {2'd0, ad_o[1]}, 32'h0DD);

    // WAIT=0 single read: ack two cycles after req is seen in IDLE
    do_reset();
    m0_req = 1'b1; m0_addr = 30'h055; pr_rd = 32'hCAFE_F00D;
    tick();
    chk("w0_c1_addr", {2'd0, ad_o[0]}, 32'h055);
    chk("w0_c1_ack", {31'd0, a0[0]}, 32'd0);
    pr_rd = 32'hA5A5_A5A5;
    tick();
    chk("w0_c2_ack", {31'd0, a0[0]}, 32'd1);
    chk("w0_c2_rdata", rd_o[0], 32'hA5A5_A5A5);
    m0_req = 1'b0; pr_rd = 32'h0F0F_0F0F;
    tick();
    chk("w0_c3_ack", {31'd0, a0[0]}, 32'd0);
    chk("w0_c3_rdata", rd_o[0], 32'hA5A5_A5A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master arbiter sitting between the CPU data port and the bridge.
- Shares the single peripheral/data bus (pr_addr/pr_wd/pr_we/pr_rd) between master 0 (CPU memory stage) and master 1 (DMA/debug requester).
- Round-robin grant; each granted access is a single-word transfer with a fixed number of bus wait cycles.
- The requester receives a one-cycle ack carrying registered read data.

Parameters:
WAIT, 1, extra ACCESS cycles before the bus data is sampled (legal range 0..15)
ADDR_HI, 31, MSB of the word address; the word address is [ADDR_HI:2]

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
m0_req  input  1  master 0 requests a transfer
m0_addr  input  30  master 0 word address [31:2]
m0_wd  input  32  master 0 write data
m0_we  input  1  master 0 write enable (1=write, 0=read)
m0_gnt  output  1  master 0 owns the bus (ACCESS or RESP)
m0_ack  output  1  one-cycle transfer-complete pulse to master 0
m1_req, m1_addr, m1_wd, m1_we, m1_gnt, m1_ack  same as the m0_* ports, for master 1
rdata  output  32  registered read data; valid while mX_ack=1
pr_addr  output  30  bus word address
pr_wd  output  32  bus write data
pr_we  output  1  bus write strobe
pr_rd  input  32  bus read data (combinational from the bridge)
busy  output  1  arbiter is not IDLE

Behaviour:
- Reset values (applied asynchronously): state=IDLE, owner=0, last=1, cnt=0, rdata=0, and every output 0.
- Reset mid-operation:
  - Immediate return to IDLE.
  - pr_we drops without waiting for a clock edge.
  - No ack is issued; the in-flight transfer is discarded.
- States: IDLE, ACCESS, RESP (2-bit encoding).
- IDLE:
  - No request: stay.
  - One request: select that master.
  - Both requesting: select the master != last (round-robin). After reset, m0 wins the first tie.
  - On selection: latch the winner's addr/wd/we into internal registers, set owner, cnt=WAIT, go to ACCESS.
- ACCESS:
  - pr_addr and pr_wd come from the latched registers.
  - pr_we = latched_we && (cnt==0), so the write strobe is high for exactly one cycle per write.
  - cnt!=0: cnt decrements each cycle.
  - cnt==0: capture pr_rd into rdata (reads only; rdata holds its old value on writes), go to RESP.
- RESP:
  - mX_ack=1 for the owner only, exactly one cycle.
  - last<=owner; go to IDLE.
  - The next request is evaluated in the following IDLE cycle.
- Outputs by state:
  - mX_gnt = (state!=IDLE) && (owner==X).
  - busy = (state!=IDLE).
  - In IDLE and RESP: pr_addr=0, pr_wd=0, pr_we=0.
- Latency: request seen in IDLE at cycle n -> ACCESS during cycles n+1..n+1+WAIT -> ack at cycle n+2+WAIT.
  - Each transfer occupies the bus for WAIT+3 cycles, IDLE included.
- Request/payload rules:
  - Masters hold req and payload until ack; the arbiter samples the payload only in IDLE.
  - Payload changes after the grant are ignored.
  - req dropped after the grant: the transfer still completes and the ack is still issued.
- Fairness: with both masters requesting continuously, grants alternate strictly (0,1,0,1...). No master waits more than one foreign transfer.
- A request arriving during ACCESS/RESP waits; it is not queued beyond the level-held req.
- Interrupt request lines (HWInt) do not pass through this block.

Test Plan:
- WAIT=1, m0 read addr 0x7F00>>2, pr_rd=0x1234_5678 -> m0_gnt high cycles 1-3, pr_addr=0x1FC0 in cycles 1-2, m0_ack cycle 3, rdata=0x12345678, pr_we never high.
- WAIT=2, m1 write addr 0x7F04>>2, wd=0xDEADBEEF -> pr_we high exactly one cycle (third ACCESS cycle) with pr_wd=0xDEADBEEF, m1_ack one cycle later, m0_ack stays 0.
- Both masters hold req continuously for 6 transfers after reset -> owner sequence 0,1,0,1,0,1; each ack spaced WAIT+3 cycles apart.
- m0 changes m0_addr and drops m0_req one cycle after the grant -> bus still shows the originally latched address, m0_ack still pulses once.
- Assert reset during the final ACCESS cycle of a write -> pr_we falls immediately, no ack, busy=0; the next request is serviced by m0 first (last=1).
- WAIT=0 single read -> ack exactly 2 cycles after req is seen in IDLE; rdata equals pr_rd sampled in the single ACCESS cycle.
